mem_arbiter_2x: RTL
===================

# mem_arbiter_2x

Two-requester arbiter and sequencer for the 16x32 single-port register memory. Accepts independent read/write requests from two masters (port 0: bus-slave side, port 1: engine side), grants one at a time, and drives the memory's chip-select/read/write/address/data strobes. It returns read data with a valid pulse, respecting the memory's registered-address read path.

## Interface
- DATA_WIDTH, 32, memory word width
- ADDRESS_WIDTH, 4, memory address width (16 words)
- iClk  in  1  rising-edge clock
- iReset  in  1  synchronous, active-high reset
- iReq0 / iReq1  in  1  request; held with command until acked
- iWe0 / iWe1  in  1  1 = write, 0 = read
- iAddr0 / iAddr1  in  ADDRESS_WIDTH  word address
- iWdata0 / iWdata1  in  DATA_WIDTH  write data
- oAck0 / oAck1  out  1  combinational accept, one cycle
- oRvalid0 / oRvalid1  out  1  read-data valid pulse
- oRdata  out  DATA_WIDTH  read data, shared; qualified by oRvalid0/1
- oMemCs, oMemRead, oMemWrite  out  1  memory strobes
- oMemAddr  out  ADDRESS_WIDTH  memory address
- oMemWdata  out  DATA_WIDTH  memory write data
- iMemRdata  in  DATA_WIDTH  memory read data (combinational from its latched address)

## Operation
- FSM states: IDLE, ISSUE, READ.
- IDLE: if any iReq, the winner gets oAckN=1 in the same cycle. On that edge: latch winner id, we, addr, wdata; go to ISSUE. No request: stay IDLE.
- ISSUE: oMemCs=1, oMemWrite=we, oMemRead=~we, oMemAddr/oMemWdata from latch. Next: write -> IDLE; read -> READ.
- READ: at the edge, capture iMemRdata into oRdata and set oRvalidN for the latched id. Next state IDLE.
- Acks are asserted only in IDLE. A requester whose iReq is high outside IDLE waits.
- Arbitration: round-robin (see Configuration). The pointer is updated on every grant to favour the non-granted port. After reset, port 0 has priority.
- Simultaneous iReq0 and iReq1 in IDLE: exactly one ack. The other port is granted on the next IDLE visit if it is still requesting.
- Dropping iReq before ack: no effect, no memory access.
- oRdata holds its last value between reads.

## Timing
- Cycle 0: iReq sampled, oAck high.
- Cycle 1: strobes high. The memory writes or latches the address at the end of cycle 1.
- Cycle 2: READ, iMemRdata valid.
- Cycle 3: oRvalid high for one cycle with oRdata.
- Throughput: write 1 per 2 cycles, read 1 per 3 cycles. Back-to-back acks are possible in cycle 2 (write) or cycle 3 (read), since that cycle is IDLE while oRvalid is high.
- Reset values: state IDLE, all strobes 0, oMemAddr 0, oMemWdata 0, oRdata 0, oRvalid0/1 0, RR pointer = port 0.
- oAck0/1 are forced to 0 while iReset=1.
- Reset mid-operation: oMemCs/oMemRead/oMemWrite are gated with ~iReset, so no memory write occurs at an edge where iReset=1. An in-flight read produces no oRvalid.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: round-robin priority pointer as described.
- Not defined: fixed priority, port 0 always wins a simultaneous request, and no pointer register is present. Port 1 can starve under continuous port 0 traffic; this is accepted behaviour.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, ISSUE, READ)
  - port id constants PORT0/PORT1
  - default DATA_WIDTH/ADDRESS_WIDTH constants
- Sub-module rr_arb2: 2-input grant logic (req[1:0], pointer -> one-hot grant). It contains the round-robin pointer when MEM_ARB_ROUND_ROBIN_EN is defined. The top instantiates it once and holds the FSM and latches.

## Test plan
- Port 0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> oAck0 in cycles 0 and 2, oMemWrite in cycle 1, oRvalid0 with oRdata=0xDEADBEEF 3 cycles after the read ack.
- iReq0 and iReq1 high continuously (reads of addr 1 and 2, with RR enabled) -> grants alternate 0,1,0,1. oRvalid0 carries mem[1] and oRvalid1 carries mem[2]; neither port waits more than one transaction.
- Same as above with the macro undefined -> only oAck0 fires while iReq0 is high. Port 1 is granted on the first IDLE after iReq0 drops.
- Request held while FSM is in ISSUE/READ -> no ack until IDLE, and exactly one memory access per ack.
- iReset asserted in the ISSUE cycle of a write of 0x12345678 to addr 3 -> mem[3] is unchanged, all outputs read back at reset values, no oRvalid.
- Port 1 writes addr 15 and reads addr 0 (address boundaries) -> correct data, oRvalid1 only, oRvalid0 stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port register-memory arbiter.
package mem_arb_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 4;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        READ  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter_2x_rr_arb2.sv
// Two-input grant logic. With MEM_ARB_ROUND_ROBIN_EN the priority pointer lives here;
// otherwise port 0 has fixed priority and no pointer register exists.
module rr_arb2
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       advance_i,
`endif
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // After a grant, priority moves to the port that was not served.
    always_comb begin
        grant_o = 2'b00;
        ptr_d   = ptr_q;
        if (req_i[0] && (!req_i[1] || ptr_q == PORT0)) begin
            grant_o = 2'b01;
        end else if (req_i[1]) begin
            grant_o = 2'b10;
        end
        if (advance_i) begin
            ptr_d = grant_o[0] ? PORT1 : PORT0;
        end
    end
`else
    always_comb begin
        grant_o = 2'b00;
        if (req_i[0]) begin
            grant_o = 2'b01;
        end else if (req_i[1]) begin
            grant_o = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter_2x.sv
// Two-requester arbiter/sequencer for the 16x32 registered-address memory.
// Optional round-robin arbitration: define MEM_ARB_ROUND_ROBIN_EN.
//   state | meaning
//   IDLE  | arbitrate, ack the winner and latch its command
//   ISSUE | drive memory strobes from the latched command
//   READ  | capture memory read data, pulse rvalid for the latched port
module mem_arbiter_2x
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
    input  logic                     iClk,
    input  logic                     iReset,
    input  logic                     iReq0,
    input  logic                     iWe0,
    input  logic [ADDRESS_WIDTH-1:0] iAddr0,
    input  logic [DATA_WIDTH-1:0]    iWdata0,
    input  logic                     iReq1,
    input  logic                     iWe1,
    input  logic [ADDRESS_WIDTH-1:0] iAddr1,
    input  logic [DATA_WIDTH-1:0]    iWdata1,
    output logic                     oAck0,
    output logic                     oAck1,
    output logic                     oRvalid0,
    output logic                     oRvalid1,
    output logic [DATA_WIDTH-1:0]    oRdata,
    output logic                     oMemCs,
    output logic                     oMemRead,
    output logic                     oMemWrite,
    output logic [ADDRESS_WIDTH-1:0] oMemAddr,
    output logic [DATA_WIDTH-1:0]    oMemWdata,
    input  logic [DATA_WIDTH-1:0]    iMemRdata
);

    state_e                   state_q, state_d;
    logic                     id_q, id_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [1:0]               rvalid_q, rvalid_d;
    logic [1:0]               grant;
    logic [1:0]               ack;

    rr_arb2 u_arb (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .clk_i     (iClk),
        .reset_i   (iReset),
        .advance_i (|ack),
`endif
        .req_i     ({iReq1, iReq0}),
        .grant_o   (grant)
    );

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 2'b00;
        ack      = 2'b00;
        case (state_q)
            IDLE: begin
                ack = grant;
                if (|grant) begin
                    id_d    = grant[1] ? PORT1 : PORT0;
                    we_d    = grant[1] ? iWe1 : iWe0;
                    addr_d  = grant[1] ? iAddr1 : iAddr0;
                    wdata_d = grant[1] ? iWdata1 : iWdata0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = we_q ? IDLE : READ;
            end
            READ: begin
                rdata_d         = iMemRdata;
                rvalid_d[id_q]  = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (iReset) begin
            ack = 2'b00;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q  <= IDLE;
            id_q     <= PORT0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Strobes are gated by reset so a reset edge can never commit a write.
    assign oMemCs    = (state_q == ISSUE) & ~iReset;
    assign oMemWrite = oMemCs & we_q;
    assign oMemRead  = oMemCs & ~we_q;
    assign oMemAddr  = addr_q;
    assign oMemWdata = wdata_q;

    assign oAck0    = ack[0];
    assign oAck1    = ack[1];
    assign oRvalid0 = rvalid_q[0];
    assign oRvalid1 = rvalid_q[1];
    assign oRdata   = rdata_q;

endmodule
